// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-and-add-3 binary to packed BCD, one bit per clock.
// Feeds the seven-segment driver with BCD digits and a significant-digit count.
//
// Ports:
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   start, bin        conversion request (taken when ready=1) and operand
//   ready             idle, start accepted this cycle
//   done              one-cycle pulse, result outputs updated this cycle
//   bcd               packed BCD result, units digit in bcd[3:0]
//   ndigits           significant digit count, 1..DIGITS
//   ovf               operand exceeded 10^DIGITS-1, bcd saturated to all 9s
module bin2bcd_seq #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            ndigits,
  output logic                  ovf
);

  // BCD field carries one guard nibble above the displayed digits
  localparam int BW = 4 * (DIGITS + 1);
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  logic [SW-1:0]       scr;
  logic [SW-1:0]       adj;
  logic [SW-1:0]       nxt;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       nbcd;
  logic                novf;
  logic [2:0]          nnd;
  logic [4*DIGITS-1:0] nout;

  // Next scratch value plus the result it would produce if this
  // were the final shift; only registered on the last SHIFT cycle.
  always_comb begin
    adj = scr;
    for (int i = 0; i <= DIGITS; i++) begin
      if (scr[WIDTH+4*i +: 4] >= 4'd5)
        adj[WIDTH+4*i +: 4] = scr[WIDTH+4*i +: 4] + 4'd3;
    end
    nxt  = {adj[SW-2:0], 1'b0};
    nbcd = nxt[SW-1:WIDTH];
    novf = |nbcd[BW-1:4*DIGITS];
    nnd  = 3'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (nbcd[4*i +: 4] != 4'd0)
        nnd = 3'(i + 1);
    end
    if (novf)
      nnd = 3'(DIGITS);
    nout = novf ? {DIGITS{4'h9}} : nbcd[4*DIGITS-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      scr     <= '0;
      cnt     <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      bcd     <= '0;
      ndigits <= 3'd1;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            scr   <= {{BW{1'b0}}, bin};
            cnt   <= CW'(WIDTH);
            ready <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= DONE;
            done    <= 1'b1;
            bcd     <= nout;
            ndigits <= nnd;
            ovf     <= novf;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq.
// Decimal reference model, latency/hold/reset monitor on the falling edge.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 20;
  localparam int DIGITS = 6;

  typedef struct {
    logic [23:0] bcd;
    logic [2:0]  nd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic             sys_clk;
  logic             sys_rst;
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             ready;
  logic             done;
  logic [23:0]      bcd;
  logic [2:0]       ndigits;
  logic             ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  int   dcyc[$];
  logic armed  = 1'b0;
  logic rst_seen = 1'b0;
  logic [27:0] prev;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .bin     (bin),
    .ready   (ready),
    .done    (done),
    .bcd     (bcd),
    .ndigits (ndigits),
    .ovf     (ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned v);
    exp_t e;
    int unsigned r;
    e.bcd = '0;
    e.nd  = 3'd1;
    e.ovf = 1'b0;
    e.cyc = 0;
    if (v > 999999) begin
      e.bcd = 24'h999999;
      e.nd  = 3'd6;
      e.ovf = 1'b1;
    end else begin
      r = v;
      for (int i = 0; i < 6; i++) begin
        e.bcd[4*i +: 4] = 4'(r % 10);
        if ((r % 10) != 0)
          e.nd = 3'(i + 1);
        r = r / 10;
      end
    end
    return e;
  endfunction

  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (armed) begin
      check("excl", {31'd0, done & ready}, 32'd0);
      if (rst_seen) begin
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {8'd0, bcd}, 32'd0);
        check("rst_nd", {29'd0, ndigits}, 32'd1);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
      end else if (done) begin
        dcyc.push_back(cyc);
        if (q.size() == 0) begin
          check("done_unexp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("bcd", {8'd0, bcd}, {8'd0, e.bcd});
          check("nd", {29'd0, ndigits}, {29'd0, e.nd});
          check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          check("lat", cyc - e.cyc, WIDTH + 1);
        end
      end else begin
        check("hold", {4'd0, bcd, ndigits, ovf}, {4'd0, prev});
      end
    end
    prev = {bcd, ndigits, ovf};
    armed = 1'b1;
    if (sys_rst) begin
      q.delete();
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (start && ready) begin
        e = model(32'(bin));
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (!ready) check("to_ready", 32'd1, 32'd0);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (q.size() != 0) check("to_done", 32'd1, 32'd0);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic conv(input int unsigned v);
    wait_ready();
    start = 1'b1;
    bin   = WIDTH'(v);
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    wait_empty();
  endtask

  initial begin
    logic r;
    int   n;
    sys_rst = 1'b1;
    start   = 1'b0;
    bin     = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    conv(0);
    conv(123456);
    conv(907);
    conv(999999);
    conv(1000000);
    conv(1048575);

    // start held high: three back-to-back conversions
    wait_ready();
    dcyc.delete();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bin = WIDTH'(k);
      n = 0;
      do begin
        r = ready;
        @(posedge sys_clk);
        #1;
        n++;
      end while (!r && n < 100);
      if (!r) check("to_accept", 32'd1, 32'd0);
    end
    start = 1'b0;
    wait_empty();
    check("ndone", dcyc.size(), 32'd3);
    if (dcyc.size() == 3) begin
      check("period0", dcyc[1] - dcyc[0], WIDTH + 2);
      check("period1", dcyc[2] - dcyc[1], WIDTH + 2);
    end

    // 42 must hold through the next conversion; starts during SHIFT ignored
    conv(42);
    wait_ready();
    start = 1'b1;
    bin   = WIDTH'(907);
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      start = ~start;
      bin   = WIDTH'($urandom_range(0, 1048575));
      @(posedge sys_clk);
      #1;
    end
    start = 1'b0;
    check("hold42", {8'd0, bcd}, 32'h000042);
    wait_empty();

    // reset on the 10th SHIFT cycle discards the conversion
    wait_ready();
    start = 1'b1;
    bin   = WIDTH'(654321);
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge sys_clk);
      #1;
    end
    sys_rst = 1'b1;
    start   = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    start   = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_bcd", {8'd0, bcd}, 32'd0);
    repeat (30) @(posedge sys_clk);
    #1;
    conv(654321);

    for (int k = 0; k < 4; k++)
      conv($urandom_range(0, 1048575));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
